// File: rtl/posit_extract_if.sv
// Handshake bundle between two posit requesters, the shared extractor and its consumer.
// The slave side is the extractor; the master side drives operands and out_ready.
interface posit_extract_if #(
  parameter int N  = 16,
  parameter int es = 2,
  parameter int TW = 8,
  parameter int Bs = $clog2(N)
);
  logic          a_valid;
  logic          a_ready;
  logic [N-1:0]  a_data;
  logic [TW-1:0] a_tag;
  logic          b_valid;
  logic          b_ready;
  logic [N-1:0]  b_data;
  logic [TW-1:0] b_tag;
  logic          out_valid;
  logic          out_ready;
  logic          out_id;
  logic [TW-1:0] out_tag;
  logic          out_sign;
  logic          out_zero;
  logic          out_nar;
  logic          out_rc;
  logic [Bs:0]   out_k;
  logic [es-1:0] out_exp;
  logic [N-es-1:0] out_frac;
  logic          busy;

  modport slave (
    input  a_valid, a_data, a_tag, b_valid, b_data, b_tag, out_ready,
    output a_ready, b_ready, out_valid, out_id, out_tag, out_sign, out_zero,
           out_nar, out_rc, out_k, out_exp, out_frac, busy
  );

  modport master (
    output a_valid, a_data, a_tag, b_valid, b_data, b_tag, out_ready,
    input  a_ready, b_ready, out_valid, out_id, out_tag, out_sign, out_zero,
           out_nar, out_rc, out_k, out_exp, out_frac, busy
  );
endinterface

// File: rtl/posit_extract_arbiter.sv
// Round-robin front end for two requesters feeding a shared two-stage posit
// field extractor: stage 1 sign-normalises, stage 2 splits regime/exponent/fraction.
module posit_extract_arbiter #(
  parameter int N  = 16,
  parameter int es = 2,
  parameter int TW = 8,
  parameter int Bs = $clog2(N)
) (
  input logic            clk,
  input logic            reset,
  posit_extract_if.slave bus
);

  localparam logic [Bs:0]        SHIFT_PAST_RUN = (Bs+1)'(2);
  localparam logic signed [Bs:0] ONE_S          = (Bs+1)'(1);

  // Length of the run of bits equal to x[N-2], scanning downward from N-2.
  function automatic logic [Bs-1:0] run_len(input logic [N-1:0] x);
    logic          run;
    logic [Bs-1:0] cnt;
    run = 1'b1;
    cnt = '0;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (x[i] == x[N-2])) cnt = cnt + Bs'(1);
      else                         run = 1'b0;
    end
    return cnt;
  endfunction

  function automatic logic signed [Bs:0] regime_k(input logic rc, input logic [Bs-1:0] m);
    logic signed [Bs:0] ms;
    ms = $signed({1'b0, m});
    return rc ? (ms - ONE_S) : -ms;
  endfunction

  logic adv1, adv2;
  logic grant_a, grant_b;
  logic ptr_q, ptr_d;

  logic            vld_p1_q, vld_p1_d;
  logic            id_p1_q, id_p1_d;
  logic [TW-1:0]   tag_p1_q, tag_p1_d;
  logic            sign_p1_q, sign_p1_d;
  logic            zero_p1_q, zero_p1_d;
  logic            nar_p1_q, nar_p1_d;
  logic [N-1:0]    abs_p1_q, abs_p1_d;

  logic            vld_p2_q, vld_p2_d;
  logic            id_p2_q, id_p2_d;
  logic [TW-1:0]   tag_p2_q, tag_p2_d;
  logic            sign_p2_q, sign_p2_d;
  logic            zero_p2_q, zero_p2_d;
  logic            nar_p2_q, nar_p2_d;
  logic            rc_p2_q, rc_p2_d;
  logic signed [Bs:0] k_p2_q, k_p2_d;
  logic [es-1:0]   exp_p2_q, exp_p2_d;
  logic [N-es-1:0] frac_p2_q, frac_p2_d;

  logic [N-1:0]    sel_data;
  logic [TW-1:0]   sel_tag;
  logic            rc_c;
  logic [Bs-1:0]   m_c;
  logic [Bs:0]     sh_c;
  logic [N-1:0]    rem_c;

  assign adv2 = !vld_p2_q | bus.out_ready;
  assign adv1 = !vld_p1_q | adv2;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
      grant_a = !ptr_q;
      grant_b = ptr_q;
    end else begin
      grant_a = bus.a_valid;
      grant_b = bus.b_valid;
    end
  end

  assign bus.a_ready = adv1 & grant_a;
  assign bus.b_ready = adv1 & grant_b;
  assign sel_data    = grant_b ? bus.b_data : bus.a_data;
  assign sel_tag     = grant_b ? bus.b_tag  : bus.a_tag;

  // Stage 1: arbitration, sign normalisation, zero/NaR detection
  always_comb begin
    ptr_d     = ptr_q;
    vld_p1_d  = vld_p1_q;
    id_p1_d   = id_p1_q;
    tag_p1_d  = tag_p1_q;
    sign_p1_d = sign_p1_q;
    zero_p1_d = zero_p1_q;
    nar_p1_d  = nar_p1_q;
    abs_p1_d  = abs_p1_q;
    if (adv1) begin
      // The pointer only moves on contention, and then to the side that lost.
      if (bus.a_valid && bus.b_valid) ptr_d = grant_a;
      vld_p1_d  = grant_a | grant_b;
      id_p1_d   = grant_b;
      tag_p1_d  = sel_tag;
      sign_p1_d = sel_data[N-1];
      zero_p1_d = (sel_data == '0);
      nar_p1_d  = (sel_data == {1'b1, {(N-1){1'b0}}});
      abs_p1_d  = sel_data[N-1] ? -sel_data : sel_data;
    end
  end

  // Stage 2: regime run, exponent and fraction extraction
  always_comb begin
    rc_c  = abs_p1_q[N-2];
    m_c   = run_len(abs_p1_q);
    sh_c  = {1'b0, m_c} + SHIFT_PAST_RUN;
    rem_c = abs_p1_q << sh_c;

    vld_p2_d  = vld_p2_q;
    id_p2_d   = id_p2_q;
    tag_p2_d  = tag_p2_q;
    sign_p2_d = sign_p2_q;
    zero_p2_d = zero_p2_q;
    nar_p2_d  = nar_p2_q;
    rc_p2_d   = rc_p2_q;
    k_p2_d    = k_p2_q;
    exp_p2_d  = exp_p2_q;
    frac_p2_d = frac_p2_q;
    if (adv2) begin
      vld_p2_d  = vld_p1_q;
      id_p2_d   = id_p1_q;
      tag_p2_d  = tag_p1_q;
      sign_p2_d = sign_p1_q;
      zero_p2_d = zero_p1_q;
      nar_p2_d  = nar_p1_q;
      if (zero_p1_q || nar_p1_q) begin
        rc_p2_d   = 1'b0;
        k_p2_d    = '0;
        exp_p2_d  = '0;
        frac_p2_d = '0;
      end else begin
        rc_p2_d   = rc_c;
        k_p2_d    = regime_k(rc_c, m_c);
        exp_p2_d  = rem_c[N-1 -: es];
        frac_p2_d = rem_c[N-es-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      id_p1_q   <= 1'b0;
      tag_p1_q  <= '0;
      sign_p1_q <= 1'b0;
      zero_p1_q <= 1'b0;
      nar_p1_q  <= 1'b0;
      abs_p1_q  <= '0;
      vld_p2_q  <= 1'b0;
      id_p2_q   <= 1'b0;
      tag_p2_q  <= '0;
      sign_p2_q <= 1'b0;
      zero_p2_q <= 1'b0;
      nar_p2_q  <= 1'b0;
      rc_p2_q   <= 1'b0;
      k_p2_q    <= '0;
      exp_p2_q  <= '0;
      frac_p2_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      vld_p1_q  <= vld_p1_d;
      id_p1_q   <= id_p1_d;
      tag_p1_q  <= tag_p1_d;
      sign_p1_q <= sign_p1_d;
      zero_p1_q <= zero_p1_d;
      nar_p1_q  <= nar_p1_d;
      abs_p1_q  <= abs_p1_d;
      vld_p2_q  <= vld_p2_d;
      id_p2_q   <= id_p2_d;
      tag_p2_q  <= tag_p2_d;
      sign_p2_q <= sign_p2_d;
      zero_p2_q <= zero_p2_d;
      nar_p2_q  <= nar_p2_d;
      rc_p2_q   <= rc_p2_d;
      k_p2_q    <= k_p2_d;
      exp_p2_q  <= exp_p2_d;
      frac_p2_q <= frac_p2_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.out_id    = id_p2_q;
  assign bus.out_tag   = tag_p2_q;
  assign bus.out_sign  = sign_p2_q;
  assign bus.out_zero  = zero_p2_q;
  assign bus.out_nar   = nar_p2_q;
  assign bus.out_rc    = rc_p2_q;
  assign bus.out_k     = k_p2_q;
  assign bus.out_exp   = exp_p2_q;
  assign bus.out_frac  = frac_p2_q;
  assign bus.busy      = vld_p1_q | vld_p2_q;

endmodule

// File: tb/tb_posit_extract_arbiter.sv
// Bench for posit_extract_arbiter: directed vector table, multi-cycle arbitration and
// stall sequences, then random traffic against an arithmetic reference model.
module tb_posit_extract_arbiter;

  typedef struct packed {
    logic        id;
    logic [7:0]  tag;
    logic        sign;
    logic        zero;
    logic        nar;
    logic        rc;
    logic [4:0]  k;
    logic [1:0]  exp;
    logic [13:0] frac;
  } res_t;

  typedef struct packed {
    logic        side;
    logic [15:0] data;
    logic [7:0]  tag;
    res_t        exp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  logic tb_ptr  = 1'b0;
  logic stalled = 1'b0;
  res_t snap;
  res_t sbq[$];
  vec_t vecs[7];

  posit_extract_if #(.N(16), .es(2), .TW(8)) bif ();

  posit_extract_arbiter #(.N(16), .es(2), .TW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Reference: regime run length from the bit length of the (inverted) magnitude.
  function automatic res_t model(input logic id, input logic [7:0] tag, input logic [15:0] x);
    res_t r;
    int a, v, b, m, kk, rem;
    r      = '0;
    r.id   = id;
    r.tag  = tag;
    r.sign = x[15];
    r.zero = (x == 16'h0000);
    r.nar  = (x == 16'h8000);
    if (r.zero || r.nar) return r;
    a    = x[15] ? (65536 - int'(x)) : int'(x);
    r.rc = a[14];
    v    = a % 32768;
    if (r.rc) v = 32767 - v;
    b = 0;
    while ((1 << b) <= v) b++;
    m      = 15 - b;
    kk     = r.rc ? (m - 1) : -m;
    r.k    = kk[4:0];
    rem    = (a << (m + 2)) % 65536;
    r.exp  = rem[15:14];
    r.frac = rem[13:0];
    return r;
  endfunction

  function automatic res_t get_out();
    res_t r;
    r.id   = bif.out_id;
    r.tag  = bif.out_tag;
    r.sign = bif.out_sign;
    r.zero = bif.out_zero;
    r.nar  = bif.out_nar;
    r.rc   = bif.out_rc;
    r.k    = bif.out_k;
    r.exp  = bif.out_exp;
    r.frac = bif.out_frac;
    return r;
  endfunction

  function automatic vec_t mk(input logic side, input logic [15:0] d, input logic [7:0] t,
                              input logic s, input logic z, input logic n, input logic rc,
                              input logic [4:0] k, input logic [1:0] e, input logic [13:0] f);
    vec_t v;
    v.side = side;
    v.data = d;
    v.tag  = t;
    v.exp  = '{id: side, tag: t, sign: s, zero: z, nar: n, rc: rc, k: k, exp: e, frac: f};
    return v;
  endfunction

  // One clock: sample at negedge+1, score, then advance to the next negedge.
  task automatic cycle();
    res_t got, e;
    #1;
    got = get_out();
    if (stalled) chk("hold", got, snap);
    chk("busy", bif.busy, (sbq.size() != 0));
    chk("excl_ready", bif.a_ready & bif.b_ready, 0);
    chk("idle_grant", (bif.a_ready & !bif.a_valid) | (bif.b_ready & !bif.b_valid), 0);
    if (bif.a_valid && bif.b_valid && (bif.a_ready || bif.b_ready)) begin
      chk("rr_grant", bif.b_ready, tb_ptr);
      tb_ptr = !tb_ptr;
    end
    if (bif.out_valid && bif.out_ready) begin
      n_out++;
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_out: got result %h required none", got);
      end else begin
        e = sbq.pop_front();
        chk("result", got, e);
      end
    end
    if (bif.a_valid && bif.a_ready) sbq.push_back(model(1'b0, bif.a_tag, bif.a_data));
    if (bif.b_valid && bif.b_ready) sbq.push_back(model(1'b1, bif.b_tag, bif.b_data));
    stalled = bif.out_valid && !bif.out_ready;
    snap    = got;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bif.a_valid   = 1'b0;
    bif.b_valid   = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) cycle();
    chk("drained", sbq.size(), 0);
  endtask

  initial begin
    int n0;
    logic [7:0] tg;
    vecs[0] = mk(1'b0, 16'h4000, 8'h11, 0, 0, 0, 1, 5'd0,  2'b00, 14'h0000);
    vecs[1] = mk(1'b0, 16'h7000, 8'h21, 0, 0, 0, 1, 5'd2,  2'b00, 14'h0000);
    vecs[2] = mk(1'b0, 16'h0800, 8'h22, 0, 0, 0, 0, 5'h1D, 2'b00, 14'h0000);
    vecs[3] = mk(1'b0, 16'h5A00, 8'h23, 0, 0, 0, 1, 5'd0,  2'b11, 14'h1000);
    vecs[4] = mk(1'b1, 16'hC000, 8'h31, 1, 0, 0, 1, 5'd0,  2'b00, 14'h0000);
    vecs[5] = mk(1'b1, 16'h0000, 8'h32, 0, 1, 0, 0, 5'd0,  2'b00, 14'h0000);
    vecs[6] = mk(1'b1, 16'h8000, 8'h33, 1, 0, 1, 0, 5'd0,  2'b00, 14'h0000);

    reset = 1'b1;
    bif.a_valid = 1'b0; bif.a_data = '0; bif.a_tag = '0;
    bif.b_valid = 1'b0; bif.b_data = '0; bif.b_tag = '0;
    bif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Put two operands in flight, then reset asynchronously between edges.
    bif.a_valid = 1'b1; bif.a_data = 16'h1234; bif.a_tag = 8'hEE;
    cycle();
    bif.a_tag = 8'hEF;
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_outputs", get_out(), '0);
    chk("rst_a_ready", bif.a_ready, 1);
    sbq.delete();
    tb_ptr  = 1'b0;
    stalled = 1'b0;
    @(negedge clk);
    bif.a_valid = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].side) begin
        bif.b_valid = 1'b1; bif.b_data = vecs[i].data; bif.b_tag = vecs[i].tag;
      end else begin
        bif.a_valid = 1'b1; bif.a_data = vecs[i].data; bif.a_tag = vecs[i].tag;
      end
      cycle();
      bif.a_valid = 1'b0;
      bif.b_valid = 1'b0;
      cycle();
      chk($sformatf("vec%0d_latency", i), bif.out_valid, 1);
      chk($sformatf("vec%0d_fields", i), get_out(), vecs[i].exp);
    end
    drain();

    // Contention: alternate A,B starting with A, one result per cycle.
    n0 = n_out;
    bif.a_valid = 1'b1; bif.b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bif.a_data = 16'h3000 + 16'(i); bif.a_tag = 8'h40 + 8'(i);
      bif.b_data = 16'hA000 + 16'(i); bif.b_tag = 8'h50 + 8'(i);
      #1;
      chk("alt_grant_b", bif.b_ready, logic'(i % 2));
      cycle();
    end
    bif.a_valid = 1'b0; bif.b_valid = 1'b0;
    cycle();
    cycle();
    chk("alt_count", n_out - n0, 6);
    drain();

    // Fill both stages, stall downstream for three cycles, then drain.
    tg = 8'h60;
    bif.a_valid = 1'b1; bif.b_valid = 1'b1; bif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bif.out_ready = 1'b0;
      bif.a_data = 16'h2345 + 16'(i); bif.a_tag = tg; tg++;
      bif.b_data = 16'hF0F0 - 16'(i); bif.b_tag = tg; tg++;
      if (i >= 2) begin
        #1;
        chk("stall_a_ready", bif.a_ready, 0);
        chk("stall_b_ready", bif.b_ready, 0);
      end
      cycle();
    end
    drain();

    // Lone B grants must not move the pointer away from A.
    bif.b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.b_data = 16'h1111 * 16'(i + 1); bif.b_tag = 8'h80 + 8'(i);
      cycle();
    end
    bif.a_valid = 1'b1; bif.a_data = 16'h6000; bif.a_tag = 8'h90;
    #1;
    chk("ptr_kept_a", bif.a_ready, 1);
    cycle();
    drain();

    for (int i = 0; i < 600; i++) begin
      bif.a_valid   = ($urandom_range(0, 3) != 0);
      bif.b_valid   = ($urandom_range(0, 3) != 0);
      bif.a_data    = 16'($urandom);
      bif.b_data    = 16'($urandom);
      bif.a_tag     = 8'($urandom);
      bif.b_tag     = 8'($urandom);
      bif.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_extract_arbiter.md
Name: posit_extract_arbiter

Overview:
- Shares one posit field-extraction datapath between two requesters (A, B) through a round-robin arbiter with valid/ready handshakes.
- Stage 1 arbitrates and sign-normalises the operand (two's complement of negative posits) and flags zero/NaR.
- Stage 2 runs the field extraction (rc, regime, exponent, fraction) and registers the result together with requester ID and tag.
- Sits ahead of the posit arithmetic units in the PairHMM posit pipeline.

Parameters:
N, 16, posit width
es, 2, exponent field width
Bs, log2(N), regime count width
TW, 8, user tag width carried alongside the operand

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
a_valid  in  1  requester A operand valid
a_ready  out  1  A accepted this cycle when a_valid & a_ready
a_data  in  N  A posit operand
a_tag  in  TW  A tag
b_valid  in  1  requester B operand valid
b_ready  out  1  B handshake ready
b_data  in  N  B posit operand
b_tag  in  TW  B tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_id  out  1  0 = A, 1 = B
out_tag  out  TW  tag of the operand
out_sign  out  1  posit sign bit
out_zero  out  1  operand was all zeros
out_nar  out  1  operand was 1 followed by zeros
out_rc  out  1  regime check bit of |x| (bit N-2)
out_k  out  Bs+1  signed regime value
out_exp  out  es  exponent field
out_frac  out  N-es  fraction field, MSB-aligned, zero-padded
busy  out  1  s1_valid | out_valid

Behaviour:
- Reset (asynchronous, immediate): s1_valid=0, out_valid=0, RR pointer=A, all data registers=0, every output 0. a_ready/b_ready follow the combinational rule below. Reset mid-operation discards in-flight operands; nothing is replayed.
- Pipeline enables:
  - adv2 = !out_valid | out_ready
  - adv1 = !s1_valid | adv2
- Arbitration, combinational when adv1=1:
  - Only one requester valid: grant it.
  - Both valid: grant the pointer side.
  - a_ready = adv1 & grantA; b_ready = adv1 & grantB. Never both 1.
  - When adv1=0, both readies are 0.
- RR pointer: updates only on a completed grant with both requesters valid, moving to the loser. A lone grant leaves it unchanged.
- Stage 1 on adv1:
  - Load s1_valid = (grant issued).
  - Register id, tag, sign = x[N-1], zero = (x==0), nar = (x == 1<<(N-1)), and abs = sign ? -x : x.
- Stage 2 on adv2:
  - out_valid <= s1_valid.
  - Fields from abs: rc = abs[N-2]. m = run length of bits equal to rc starting at bit N-2, capped at N-1.
  - k = rc ? m-1 : -m, in two's complement, Bs+1 bits.
  - Remove the regime run plus its terminating bit. exp = next es bits, frac = remaining bits left-aligned, zero-filled. Bits beyond the word read as 0.
  - Zero and NaR force rc=0, k=0, exp=0, frac=0; only the flag is set.
- Latency: 2 cycles from handshake to out_valid with no stall. Throughput: 1 per cycle.
- Output stability: while out_valid & !out_ready, all out_* hold. Stall propagates back to the readies within the same cycle.
- Ordering: results leave in grant order; no reordering.

Test Plan:
- Reset with a_valid=1 and data in flight -> out_valid=0 immediately; after release, A data 0x4000 tag 0x11 -> 2 cycles later out_id=0, tag 0x11, sign 0, rc 1, k=0, exp 0, frac 0.
- A: 0x7000 -> k=+2, exp=00, frac=0. A: 0x0800 -> rc=0, k=-3, exp=00, frac=0. A: 0x5A00 -> k=0, exp=11, frac=0x1000.
- B: 0xC000 -> sign=1, k=0, exp=0, frac=0. B: 0x0000 -> out_zero=1. B: 0x8000 -> out_nar=1, other fields 0.
- A and B both valid for 6 cycles, out_ready=1 -> grants alternate A,B,A,B,A,B starting with A; one result per cycle; ids alternate.
- out_ready=0 for 3 cycles with both stages full -> a_ready=b_ready=0, outputs held. Raising out_ready drains with no loss or duplication, verified via tags.
- Only B valid repeatedly, then both valid -> pointer still A, so A granted first.
